gpio_led_arbiter: RTL and testbench

//  Shares the single 8-bit LED indicator write port (data + 1-cycle valid) among NUM_REQ

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_rr_pick.sv | 68 ++++++
 rtl/gpio_led_arbiter.sv | 143 ++++++++++++++
 tb/tb_gpio_led_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO LED arbiter: FSM state encoding and default sizing.
package gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } gpio_state_e;

    localparam int GPIO_DATA_W      = 8;
    localparam int GPIO_HOLD_CYCLES = 1000000;
    localparam int GPIO_CNT_W       = 24;
    localparam int GPIO_MAX_REQ     = 8;
    localparam int GPIO_ID_W        = 3;

endpackage

// File: rtl/gpio_rr_pick.sv
// Combinational requester picker: round-robin after the last grant, or fixed
// priority with requester 0 highest. Produces a one-hot grant and its index.
module gpio_rr_pick
    import gpio_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [GPIO_ID_W-1:0] i_last,
    input  logic                 i_prio_mode,
    output logic [NUM_REQ-1:0]   o_grant_oh,
    output logic [GPIO_ID_W-1:0] o_grant_idx,
    output logic                 o_grant_any
);

    logic [NUM_REQ-1:0]   w_upper;
    logic [NUM_REQ-1:0]   w_cand;
    logic [GPIO_ID_W-1:0] w_idx;

    // Requesters that sit strictly after the last granted index.
    always_comb begin
        w_upper = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i > int'(i_last)) begin
                w_upper[i] = i_req_valid[i];
            end else begin
                w_upper[i] = 1'b0;
            end
        end
    end

    // Candidate set: fixed mode uses all requests; round-robin prefers those after
    // the pointer and wraps to the full set when none remain above it.
    always_comb begin
        w_cand = i_req_valid;
        if (i_prio_mode) begin
            w_cand = i_req_valid;
        end else if (|w_upper) begin
            w_cand = w_upper;
        end else begin
            w_cand = i_req_valid;
        end
    end

    // Lowest set index of the candidate set (scan high to low, last hit wins).
    always_comb begin
        w_idx = {GPIO_ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_idx = GPIO_ID_W'(i);
            end else begin
                w_idx = w_idx;
            end
        end
    end

    // One-hot form of the chosen index, empty when nothing is requesting.
    always_comb begin
        o_grant_oh = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant_oh[i] = w_cand[i] && (w_idx == GPIO_ID_W'(i));
        end
    end

    assign o_grant_idx = w_idx;
    assign o_grant_any = |i_req_valid;

endmodule

// File: rtl/gpio_led_arbiter.sv
// Shares one LED indicator write port among NUM_REQ requesters and enforces a
// minimum interval between LED updates: IDLE -> ISSUE -> HOLD -> IDLE.
module gpio_led_arbiter
    import gpio_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = GPIO_DATA_W,
    parameter int HOLD_CYCLES = GPIO_HOLD_CYCLES,
    parameter int CNT_W       = GPIO_CNT_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        prio_mode,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           led_data,
    output logic                        led_valid,
    output logic [GPIO_ID_W-1:0]        grant_id,
    output logic                        busy
);

    localparam logic [GPIO_ID_W-1:0] LAST_RST  = GPIO_ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

    gpio_state_e            r_state;
    gpio_state_e            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [GPIO_ID_W-1:0]   r_last;
    logic [DATA_W-1:0]      r_led_data;
    logic                   r_led_valid;
    logic [GPIO_ID_W-1:0]   r_grant_id;
    logic                   r_busy;

    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [GPIO_ID_W-1:0]   w_grant_idx;
    logic                   w_grant_any;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_sel_data;

    gpio_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_last      (r_last),
        .i_prio_mode (prio_mode),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // Grant is offered only in IDLE; it is also masked while reset is held so a
    // requester never sees ready for a transfer the reset would discard.
    assign w_ready   = ((r_state == ST_IDLE) && rstn && w_grant_any) ? w_grant_oh : {NUM_REQ{1'b0}};
    assign w_accept  = |(req_valid & w_ready);
    assign req_ready = w_ready;

    // Select the winning requester's data word.
    always_comb begin
        w_sel_data = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end else begin
                w_sel_data = w_sel_data;
            end
        end
    end

    // Next-state and hold-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                w_cnt_nxt = {CNT_W{1'b0}};
            end
            ST_ISSUE: begin
                if (HOLD_CYCLES == 32'sd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt >= HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered outputs; a transfer captures data, id and pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_last      <= LAST_RST;
            r_led_data  <= {DATA_W{1'b0}};
            r_led_valid <= 1'b0;
            r_grant_id  <= {GPIO_ID_W{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_led_valid <= (w_state_nxt == ST_ISSUE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_led_data <= w_sel_data;
                r_grant_id <= w_grant_idx;
                r_last     <= w_grant_idx;
            end else begin
                r_led_data <= r_led_data;
                r_grant_id <= r_grant_id;
                r_last     <= r_last;
            end
        end
    end

    assign led_data  = r_led_data;
    assign led_valid = r_led_valid;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_gpio_led_arbiter.sv
// Self-checking bench for gpio_led_arbiter (NUM_REQ=4, HOLD_CYCLES=4).
module tb_gpio_led_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int HC = 4;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          prio_mode = 1'b0;
    logic [NR-1:0] req_valid = 4'd0;
    logic [31:0]   req_data = 32'd0;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] led_data;
    logic          led_valid;
    logic [2:0]    grant_id;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int q_gid[$];
    int q_data[$];
    int q_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_led_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .HOLD_CYCLES (HC),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .prio_mode (prio_mode),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .led_data  (led_data),
        .led_valid (led_valid),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Reference arbitration rule: fixed = lowest index; RR = first valid after last, wrapping.
    function automatic int pick(input logic [3:0] v, input logic pm, input int last);
        if (v == 4'd0) return -1;
        if (pm) begin
            for (int i = 0; i < NR; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (last + k) % NR;
                if (v[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = 4'd0;
        prio_mode = 1'b0;
        req_data = 32'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Record every LED pulse (id, data, cycle) seen over ncyc cycles.
    task automatic collect(input int ncyc);
        q_gid.delete();
        q_data.delete();
        q_cyc.delete();
        repeat (ncyc) begin
            @(negedge clk);
            if (led_valid) begin
                q_gid.push_back(int'(grant_id));
                q_data.push_back(int'(led_data));
                q_cyc.push_back(cyc);
            end
        end
    endtask

    // Present one request until granted, drop it, then wait for the arbiter to go idle.
    task automatic grant_one(input logic [3:0] v, output bit ok);
        bit got;
        got = 1'b0;
        ok = 1'b0;
        req_valid = v;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (req_ready != 4'd0) got = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (!busy) ok = got;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 4'hF;
        req_data = 32'h13121110;
        @(negedge clk);
        n_checks += 5;
        if (req_ready !== 4'd0) begin n_errors++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
        if (led_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", led_valid); end
        if (led_data !== 8'd0)  begin n_errors++; $display("FAIL reset_data got=%h exp=0", led_data); end
        if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (grant_id !== 3'd0)  begin n_errors++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        req_valid = 4'd0;
    endtask

    task automatic test_single();
        int n_busy;
        int n_pulse;
        int n_ready;
        do_reset();
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        n_busy = 0; n_pulse = 0; n_ready = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (led_valid) n_pulse++;
            if (req_ready != 4'd0) n_ready++;
            if (c == 0) begin
                n_checks += 3;
                if (led_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got=%b exp=1", led_valid); end
                if (led_data !== 8'hA5) begin n_errors++; $display("FAIL single_data got=%h exp=a5", led_data); end
                if (grant_id !== 3'd2)  begin n_errors++; $display("FAIL single_gid got=%0d exp=2", grant_id); end
            end
        end
        n_checks += 4;
        if (n_busy != HC)  begin n_errors++; $display("FAIL single_busy_cycles got=%0d exp=%0d", n_busy, HC); end
        if (n_pulse != 1)  begin n_errors++; $display("FAIL single_pulses got=%0d exp=1", n_pulse); end
        if (n_ready != 0)  begin n_errors++; $display("FAIL single_extra_ready got=%0d exp=0", n_ready); end
        if (led_data !== 8'hA5) begin n_errors++; $display("FAIL single_data_hold got=%h exp=a5", led_data); end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        req_data = 32'h13121110;
        req_valid = 4'hF;
        collect(26);
        req_valid = 4'd0;
        n_checks++;
        if (q_data.size() < 5) begin
            n_errors++; $display("FAIL rr_pulse_count got=%0d exp>=5", q_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (q_data[i] != 8'h10 + (i % NR)) begin
                    n_errors++; $display("FAIL rr_seq[%0d] got=%h exp=%h", i, q_data[i], 8'h10 + (i % NR));
                end
            end
            for (int i = 1; i < 5; i++) begin
                n_checks++;
                if (q_cyc[i] - q_cyc[i-1] != HC + 1) begin
                    n_errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i, q_cyc[i] - q_cyc[i-1], HC + 1);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        prio_mode = 1'b1;
        req_data = 32'h44332211;
        req_valid = 4'b1010;
        collect(26);
        n_checks++;
        if (q_gid.size() < 4) begin n_errors++; $display("FAIL fixed_pulse_count got=%0d exp>=4", q_gid.size()); end
        foreach (q_gid[i]) begin
            n_checks++;
            if (q_gid[i] != 1 || q_data[i] != 8'h22) begin
                n_errors++; $display("FAIL fixed_winner[%0d] got=%0d/%h exp=1/22", i, q_gid[i], q_data[i]);
            end
        end
        req_valid = 4'b1000;
        collect(8);
        req_valid = 4'd0;
        n_checks++;
        if (q_gid.size() < 1 || q_gid[0] != 3) begin
            n_errors++; $display("FAIL fixed_loser_served got=%0d exp=3", (q_gid.size() > 0) ? q_gid[0] : -1);
        end
    endtask

    task automatic test_wrap();
        bit ok1;
        bit ok2;
        do_reset();
        req_data = 32'hD3C2B1A0;
        grant_one(4'b0010, ok1);
        grant_one(4'b1000, ok2);
        n_checks++;
        if (!(ok1 && ok2)) begin n_errors++; $display("FAIL wrap_setup_timeout got=%b%b exp=11", ok1, ok2); end
        req_valid = 4'b0011;
        collect(12);
        req_valid = 4'd0;
        n_checks++;
        if (q_gid.size() < 2) begin
            n_errors++; $display("FAIL wrap_pulse_count got=%0d exp>=2", q_gid.size());
        end else begin
            n_checks += 2;
            if (q_gid[0] != 0) begin n_errors++; $display("FAIL wrap_first got=%0d exp=0", q_gid[0]); end
            if (q_gid[1] != 1) begin n_errors++; $display("FAIL wrap_second got=%0d exp=1", q_gid[1]); end
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        req_data = 32'h44332211;
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        n_checks++;
        if (led_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_issue got=%b exp=1", led_valid); end
        rstn = 1'b0;
        #1;
        n_checks += 3;
        if (led_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid_drop got=%b exp=0", led_valid); end
        if (busy !== 1'b0)      begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (led_data !== 8'd0)  begin n_errors++; $display("FAIL midrst_data got=%h exp=0", led_data); end
        @(negedge clk);
        req_valid = 4'hF;
        rstn = 1'b1;
        collect(4);
        req_valid = 4'd0;
        n_checks++;
        if (q_gid.size() < 1 || q_gid[0] != 0) begin
            n_errors++; $display("FAIL midrst_first_winner got=%0d exp=0", (q_gid.size() > 0) ? q_gid[0] : -1);
        end
    endtask

    // Random traffic against a cycle-level reference: pointer, pending-pulse flag and
    // cycles of busy time remaining after each accepted update.
    task automatic test_random();
        int m_last;
        int m_left;
        bit m_pulse;
        int e_data;
        int e_gid;
        int g;
        logic [3:0] exp_ready;
        do_reset();
        m_last = NR - 1; m_left = 0; m_pulse = 1'b0; e_data = 0; e_gid = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req_data[i*8 +: 8] = 8'($urandom);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(15) == 0) prio_mode = ~prio_mode;
            @(negedge clk);
            g = (m_left == 0) ? pick(req_valid, prio_mode, m_last) : -1;
            exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
            n_checks += 5;
            if (req_ready !== exp_ready)    begin n_errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            if (led_valid !== m_pulse)      begin n_errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, led_valid, m_pulse); end
            if (led_data !== 8'(e_data))    begin n_errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, led_data, e_data); end
            if (grant_id !== 3'(e_gid))     begin n_errors++; $display("FAIL rnd_gid c=%0d got=%0d exp=%0d", c, grant_id, e_gid); end
            if (busy !== (m_left > 0))      begin n_errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_left > 0); end
            @(posedge clk);
            if (g >= 0) begin
                m_last = g;
                e_data = int'(req_data[g*8 +: 8]);
                e_gid = g;
                m_pulse = 1'b1;
                m_left = HC;
            end else begin
                m_pulse = 1'b0;
                if (m_left > 0) m_left--;
            end
            #1;
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed_priority();
        test_wrap();
        test_midop_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
